// File: rtl/sr_cmd_pkg.sv
// Shared types and constants for the SR command generator: FSM states,
// simultaneous-event policy codes and the conflict counter width.
package sr_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    HOLDOFF = 2'd2
  } state_e;

  localparam int PRIO_RST  = 0;
  localparam int PRIO_SET  = 1;
  localparam int PRIO_DROP = 2;

  localparam int CONF_CNT_W = 8;

endpackage

// File: rtl/sr_debounce.sv
// One request channel: 2-flop synchroniser, stability counter, debounced
// level and a registered single-cycle pulse on each 0->1 level change.
module sr_debounce #(
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;
  logic             level_prev_q;
  logic             rise_q;

  // Any agreement between sample and level restarts the stability run.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      rise_q       <= 1'b0;
    end else begin
      sync1_q      <= raw_i;
      sync2_q      <= sync1_q;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
      rise_q       <= level_q & ~level_prev_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/sr_cmd_gen.sv
// SR command generator: debounces set/reset requests and issues mutually
// exclusive one-cycle s_o/r_o pulses. Optional: SR_CMD_CONFLICT_CNT_EN adds conflict_cnt_o.
module sr_cmd_gen
  import sr_cmd_pkg::*;
#(
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = 5,
  parameter int PRIO      = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic set_req_i,
  input  logic rst_req_i,
  output logic s_o,
  output logic r_o,
  output logic busy_o,
  output logic conflict_o
`ifdef SR_CMD_CONFLICT_CNT_EN
  ,
  output logic [CONF_CNT_W-1:0] conflict_cnt_o
`endif
);

  logic   set_lvl;
  logic   set_ev;
  logic   rst_lvl;
  logic   rst_ev;
  logic   both_ev;
  state_e state_q;
  logic   s_q;
  logic   r_q;
  logic   busy_q;
  logic   conf_q;

  sr_debounce #(
    .DB_CYCLES(DB_CYCLES),
    .CNT_W    (CNT_W)
  ) u_set_db (
    .clk    (clk),
    .reset  (reset),
    .raw_i  (set_req_i),
    .level_o(set_lvl),
    .rise_o (set_ev)
  );

  sr_debounce #(
    .DB_CYCLES(DB_CYCLES),
    .CNT_W    (CNT_W)
  ) u_rst_db (
    .clk    (clk),
    .reset  (reset),
    .raw_i  (rst_req_i),
    .level_o(rst_lvl),
    .rise_o (rst_ev)
  );

  assign both_ev = set_ev & rst_ev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      busy_q  <= 1'b0;
      conf_q  <= 1'b0;
    end else begin
      s_q    <= 1'b0;
      r_q    <= 1'b0;
      conf_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (set_ev || rst_ev) begin
            state_q <= ISSUE;
            busy_q  <= 1'b1;
            if (both_ev) begin
              // Drop policy still enters ISSUE so holdoff applies uniformly.
              conf_q <= 1'b1;
              if (PRIO == PRIO_SET) begin
                s_q <= 1'b1;
              end else if (PRIO == PRIO_RST) begin
                r_q <= 1'b1;
              end
            end else begin
              s_q <= set_ev;
              r_q <= rst_ev;
            end
          end
        end
        ISSUE: begin
          state_q <= HOLDOFF;
          busy_q  <= 1'b1;
        end
        HOLDOFF: begin
          if (!set_lvl && !rst_lvl) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign s_o        = s_q;
  assign r_o        = r_q;
  assign busy_o     = busy_q;
  assign conflict_o = conf_q;

`ifdef SR_CMD_CONFLICT_CNT_EN
  logic [CONF_CNT_W-1:0] conf_cnt_q;
  logic [CONF_CNT_W-1:0] conf_cnt_d;

  // Counts in step with conflict_o and sticks at all-ones.
  always_comb begin
    conf_cnt_d = conf_cnt_q;
    if ((state_q == IDLE) && both_ev && (conf_cnt_q != '1)) begin
      conf_cnt_d = conf_cnt_q + CONF_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conf_cnt_q <= '0;
    end else begin
      conf_cnt_q <= conf_cnt_d;
    end
  end

  assign conflict_cnt_o = conf_cnt_q;
`endif

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Bench for sr_cmd_gen: three instances (PRIO 0/1/2) on shared inputs, checked
// every cycle against a window-based reference model of the request rules.
module tb_sr_cmd_gen;

  localparam int DB = 16;

  logic       clk;
  logic       reset;
  logic       set_req;
  logic       rst_req;
  logic [2:0] s_v;
  logic [2:0] r_v;
  logic [2:0] b_v;
  logic [2:0] c_v;
`ifdef SR_CMD_CONFLICT_CNT_EN
  logic [7:0] cnt_v [3];
`endif

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sr_cmd_gen #(
      .DB_CYCLES(DB),
      .CNT_W    (5),
      .PRIO     (g)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .set_req_i (set_req),
      .rst_req_i (rst_req),
      .s_o       (s_v[g]),
      .r_o       (r_v[g]),
      .busy_o    (b_v[g]),
      .conflict_o(c_v[g])
`ifdef SR_CMD_CONFLICT_CNT_EN
      ,
      .conflict_cnt_o(cnt_v[g])
`endif
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Reference model state: raw sample histories, level histories, busy tracking.
  logic [63:0] hs;
  logic [63:0] hr;
  logic [2:0]  ls_h;
  logic [2:0]  lr_h;
  logic        m_busy;
  int          m_age;
  logic [2:0]  e_s;
  logic [2:0]  e_r;
  logic        e_c;
  int          m_cnt;
  int          n_s [3];
  int          n_r [3];
  int          n_c [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    hs     = '0;
    hr     = '0;
    ls_h   = '0;
    lr_h   = '0;
    m_busy = 1'b0;
    m_age  = 0;
    e_s    = '0;
    e_r    = '0;
    e_c    = 1'b0;
    m_cnt  = 0;
  endtask

  // A level flips once the last DB synchronised samples all disagree with it.
  function automatic logic next_lvl(input logic [63:0] h, input logic cur);
    logic [DB-1:0] w;
    w = h[DB+1:2];
    if (cur) return (w == '0) ? 1'b0 : 1'b1;
    return (&w) ? 1'b1 : 1'b0;
  endfunction

  task automatic model_edge();
    logic evs, evr, ols, olr;
    if (!reset) begin
      model_clear();
    end else begin
      hs  = {hs[62:0], set_req};
      hr  = {hr[62:0], rst_req};
      ols = ls_h[0];
      olr = lr_h[0];
      evs = ls_h[1] & ~ls_h[2];
      evr = lr_h[1] & ~lr_h[2];
      ls_h = {ls_h[1:0], next_lvl(hs, ols)};
      lr_h = {lr_h[1:0], next_lvl(hr, olr)};
      e_s = '0;
      e_r = '0;
      e_c = 1'b0;
      if (!m_busy) begin
        if (evs || evr) begin
          m_busy = 1'b1;
          m_age  = 0;
          if (evs && evr) begin
            e_c = 1'b1;
            e_r = 3'b001;
            e_s = 3'b010;
            if (m_cnt < 255) m_cnt++;
          end else begin
            e_s = {3{evs}};
            e_r = {3{evr}};
          end
        end
      end else begin
        m_age++;
        if (m_age >= 2 && !ols && !olr) m_busy = 1'b0;
      end
    end
  endtask

  task automatic check_outs();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("s_o[%0d]", i), 32'(s_v[i]), 32'(e_s[i]));
      chk($sformatf("r_o[%0d]", i), 32'(r_v[i]), 32'(e_r[i]));
      chk($sformatf("conflict_o[%0d]", i), 32'(c_v[i]), 32'(e_c));
      chk($sformatf("busy_o[%0d]", i), 32'(b_v[i]), 32'(m_busy));
      chk($sformatf("s_and_r[%0d]", i), 32'(s_v[i] & r_v[i]), 32'd0);
`ifdef SR_CMD_CONFLICT_CNT_EN
      chk($sformatf("conflict_cnt_o[%0d]", i), 32'(cnt_v[i]), 32'(m_cnt));
`endif
      n_s[i] += int'(s_v[i]);
      n_r[i] += int'(r_v[i]);
      n_c[i] += int'(c_v[i]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    check_outs();
  endtask

  task automatic drive(input logic s, input logic r, input int n);
    set_req = s;
    rst_req = r;
    repeat (n) step();
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 3; i++) begin
      n_s[i] = 0;
      n_r[i] = 0;
      n_c[i] = 0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    set_req  = 1'b0;
    rst_req  = 1'b0;
    model_clear();
    clear_counts();

    // Held in reset with inputs toggling.
    for (int i = 0; i < 10; i++) begin
      set_req = 1'($urandom_range(0, 1));
      rst_req = 1'($urandom_range(0, 1));
      step();
    end
    set_req = 1'b0;
    rst_req = 1'b0;
    #2 reset = 1'b1;
    drive(0, 0, 5);

    // Clean set: latency, pulse, busy tail.
    clear_counts();
    set_req = 1'b1;
    k = 0;
    step();
    while (s_v[0] !== 1'b1 && k < 200) begin step(); k++; end
    chk("lat_set", k, 19);
    drive(1, 0, 10);
    chk("set_pulses", n_s[0], 1);
    chk("set_no_r", n_r[0], 0);
    set_req = 1'b0;
    k = 0;
    step();
    while (b_v[0] !== 1'b0 && k < 200) begin step(); k++; end
    chk("busy_tail", k, 18);
    drive(0, 0, 5);

    // Glitch rejection then a long hold.
    clear_counts();
    drive(1, 0, 10);
    drive(0, 0, 1);
    drive(1, 0, 10);
    chk("glitch_none", n_s[0], 0);
    drive(1, 0, 20);
    chk("glitch_then_one", n_s[0], 1);
    drive(0, 0, 40);

    // Simultaneous rise.
    clear_counts();
    drive(1, 1, 25);
    chk("conf_p0_r", n_r[0], 1);
    chk("conf_p0_s", n_s[0], 0);
    chk("conf_p1_s", n_s[1], 1);
    chk("conf_p1_r", n_r[1], 0);
    chk("conf_p2_sr", n_s[2] + n_r[2], 0);
    chk("conf_p2_c", n_c[2], 1);
    drive(0, 0, 40);

    // Holdoff discards an event.
    clear_counts();
    drive(1, 0, 30);
    drive(1, 1, 30);
    chk("holdoff_no_r", n_r[0], 0);
    drive(0, 0, 40);
    chk("holdoff_idle", 32'(b_v[0]), 32'd0);
    drive(0, 1, 30);
    chk("holdoff_r_after", n_r[0], 1);
    drive(0, 0, 40);

    // Reset in the s_o cycle, then re-rise after release.
    set_req = 1'b1;
    k = 0;
    step();
    while (s_v[0] !== 1'b1 && k < 200) begin step(); k++; end
    chk("lat_set2", k, 19);
    #1 reset = 1'b0;
    model_clear();
    #1;
    check_outs();
    chk("cut_s", 32'(s_v[0]), 32'd0);
    step();
    #1 reset = 1'b1;
    k = 0;
    step();
    while (s_v[0] !== 1'b1 && k < 200) begin step(); k++; end
    chk("lat_after_reset", k, 19);
    drive(0, 0, 40);

    // Random bouncy segments.
    for (int seg = 0; seg < 60; seg++) begin
      logic s, r;
      s = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 2) == 0) ? s : 1'($urandom_range(0, 1));
      drive(s, r, $urandom_range(1, 40));
    end
    drive(0, 0, 40);

`ifdef SR_CMD_CONFLICT_CNT_EN
    for (int j = 0; j < 300; j++) begin
      drive(1, 1, 24);
      drive(0, 0, 22);
    end
    chk("cnt_sat", 32'(cnt_v[0]), 32'd255);
    #2 reset = 1'b0;
    model_clear();
    #1;
    chk("cnt_clear", 32'(cnt_v[0]), 32'd0);
    step();
    #2 reset = 1'b1;
    drive(0, 0, 5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
